// File: rtl/twoc_to_sm_unit.sv
// rtl/twoc_to_sm_unit.sv - registered two's-complement to sign-magnitude converter
// Optional second output register stage enabled by defining TWOC_SM_PIPE2_EN.
module twoc_to_sm_unit #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] T,
    output logic             out_valid,
    output logic [WIDTH-1:0] SM,
    output logic             signbit
);

    logic [WIDTH-1:0] w_mag;
    logic             w_sign;

    // Negating the most-negative value wraps back to itself, which read as
    // unsigned is exactly the magnitude 2^(WIDTH-1).
    assign w_sign = T[WIDTH-1];
    assign w_mag  = w_sign ? (~T + WIDTH'(1)) : T;

    logic             r_valid1;
    logic [WIDTH-1:0] r_sm1;
    logic             r_sign1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid1 <= 1'b0;
            r_sm1    <= '0;
            r_sign1  <= 1'b0;
        end else begin
            r_valid1 <= in_valid;
            if (in_valid) begin
                r_sm1   <= w_mag;
                r_sign1 <= w_sign;
            end
        end
    end

`ifdef TWOC_SM_PIPE2_EN
    logic             r_valid2;
    logic [WIDTH-1:0] r_sm2;
    logic             r_sign2;

    // Data advances only with a valid result so idle cycles keep holding it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid2 <= 1'b0;
            r_sm2    <= '0;
            r_sign2  <= 1'b0;
        end else begin
            r_valid2 <= r_valid1;
            if (r_valid1) begin
                r_sm2   <= r_sm1;
                r_sign2 <= r_sign1;
            end
        end
    end

    assign out_valid = r_valid2;
    assign SM        = r_sm2;
    assign signbit   = r_sign2;
`else
    assign out_valid = r_valid1;
    assign SM        = r_sm1;
    assign signbit   = r_sign1;
`endif

endmodule

// File: tb/tb_twoc_to_sm_unit.sv
// tb/tb_twoc_to_sm_unit.sv - randomized self-checking bench for twoc_to_sm_unit
module tb_twoc_to_sm_unit;

    localparam int W = 11;
`ifdef TWOC_SM_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] T = '0;
    logic         out_valid;
    logic [W-1:0] SM;
    logic         signbit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit v;
        int mag;
        bit s;
    } ent_t;

    ent_t pipe_q[$];
    bit   exp_valid = 1'b0;
    int   exp_mag   = 0;
    bit   exp_sign  = 1'b0;

    twoc_to_sm_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .T        (T),
        .out_valid(out_valid),
        .SM       (SM),
        .signbit  (signbit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe_q.delete();
        exp_valid = 1'b0;
        exp_mag   = 0;
        exp_sign  = 1'b0;
    endtask

    // Behavioural reference: plain signed arithmetic, delayed by LAT edges.
    task automatic model_edge(input bit v, input logic [W-1:0] t);
        ent_t e;
        ent_t o;
        int   sv;
        sv    = int'($signed(t));
        e.v   = v;
        e.s   = (sv < 0);
        e.mag = (sv < 0) ? -sv : sv;
        pipe_q.push_back(e);
        if (pipe_q.size() >= LAT) begin
            o = pipe_q.pop_front();
            exp_valid = o.v;
            if (o.v) begin
                exp_mag  = o.mag;
                exp_sign = o.s;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, int'(out_valid), int'(exp_valid));
        check({tag, ".sm"}, int'(SM), exp_mag);
        check({tag, ".sign"}, int'(signbit), int'(exp_sign));
    endtask

    task automatic cycle(input string tag, input bit v, input logic [W-1:0] t);
        in_valid = v;
        T        = t;
        @(posedge clk);
        model_edge(v, t);
        #1;
        check_outputs(tag);
    endtask

    task automatic flush(input string tag);
        for (int i = 0; i < LAT + 1; i++) cycle(tag, 1'b0, W'($urandom));
    endtask

    initial begin
        // Reset held with valid input present: outputs must stay clear.
        in_valid = 1'b1;
        T        = W'(-5);
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outputs("in_reset");
        end
        #1 rst_n = 1'b1;
        in_valid = 1'b0;

        for (int i = 0; i < 5; i++) cycle("idle", 1'b0, W'($urandom));

        cycle("zero", 1'b1, W'(0));
        flush("zero_f");
        cycle("minus1", 1'b1, W'(-1));
        flush("minus1_f");
        cycle("most_neg", 1'b1, {1'b1, {(W-1){1'b0}}});
        flush("most_neg_f");
        cycle("most_pos", 1'b1, {1'b0, {(W-1){1'b1}}});
        flush("most_pos_f");

        cycle("b2b0", 1'b1, W'(5));
        cycle("b2b1", 1'b1, W'(-5));
        cycle("b2b2", 1'b1, W'(300));
        cycle("b2b3", 1'b1, W'(-300));
        flush("b2b_f");

        cycle("hold0", 1'b1, W'(-7));
        for (int i = 0; i < 4; i++) cycle("hold_gap", 1'b0, W'(123));

        // Async reset between edges with a result still in flight.
        cycle("pre_rst_a", 1'b1, W'(-77));
        cycle("pre_rst_b", 1'b1, W'(200));
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        #2 rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) cycle("post_rst_idle", 1'b0, W'($urandom));
        cycle("post_rst", 1'b1, W'(-9));
        flush("post_rst_f");

        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] t;
            case ($urandom_range(0, 9))
                0: t = {1'b1, {(W-1){1'b0}}};
                1: t = '0;
                2: t = '1;
                default: t = W'($urandom);
            endcase
            cycle("rand", ($urandom_range(0, 3) != 0), t);
        end
        flush("rand_f");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
